key_expansion_seq: RTL and testbench
====================================

Name: key_expansion_seq

Overview:
Iterative AES key-schedule generator supporting AES-128, AES-192 and AES-256. It produces one 32-bit schedule word per clock into an internal word store. The round-key consumer reads the store through a registered read port. It replaces the flat combinational 128-bit expander and reduces S-box count from 40 to 4.

Parameters:
MAX_NK, 8, largest key length in words supported (8 = AES-256); sets key_in width to 32*MAX_NK.
MAX_NW, 60, word-store depth; must equal 4*(MAX_NK+7).
IDX_W, 6, read-index width; must satisfy 2**IDX_W >= MAX_NW.

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  reset, synchronous, active-low
start  in  1  request expansion; sampled only in IDLE
key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled with start
key_in  in  32*MAX_NK  key, left-justified: word 0 = key_in[MSB-:32]; unused low words ignored
busy  out  1  high from LOAD through EXPAND
done  out  1  one-cycle pulse when the schedule is complete
key_valid  out  1  level; store holds a complete schedule
rd_idx  in  IDX_W  word index to read
rd_word  out  32  store[rd_idx], registered, 1-cycle latency

Behaviour:
- Reset (n_rst=0 at a clk edge): state=IDLE; busy, done, key_valid, rd_word and the rcon register all cleared. Reset mid-operation aborts the expansion; the partial schedule is never flagged valid.
- Derived values at start: Nk = 4/6/8; Nw = 44/52/60.
- If start arrives with key_len=3, the block stays in IDLE and key_valid is unchanged.
- IDLE: a start pulse latches key_len and key_in, clears key_valid, then moves to LOAD.
- Start while busy is ignored.
- LOAD (1 cycle): writes words 0..Nk-1 of the store; sets i=Nk and rcon=0x01; moves to EXPAND.
- EXPAND (Nw-Nk cycles): each cycle writes w[i] = w[i-Nk] ^ t, then i increments.
  - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon), with 0x80 -> 0x1b.
  - Nk == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
- After writing w[Nw-1], the state moves to DONE.
- DONE (1 cycle): done=1; key_valid set; then moves to IDLE.
- Latency from the edge sampling start to the done-high cycle: Nw-Nk+2 edges, i.e. 42/48/54.
- i mod Nk uses a wrap counter (0..Nk-1), not a divider.
- Read port:
  - Reads are legal at any time.
  - During busy, indices >= i return stale or undefined data.
  - rd_idx >= Nw returns stale data.
  - rd_idx >= MAX_NW returns 0.
- A read and a write to the same index in the same cycle return the old value.

Optional Feature:
Macro KEY_EXP_ZEROIZE_EN.
- Defined: the word store is cleared to 0 on reset. LOAD also clears all words >= Nk, so stale key material from a prior longer key never remains readable.
- Undefined: the store has no reset; words outside the new schedule keep old contents.

Decomposition:
- Package aes_pkg:
  - key_len_t enum (AES128, AES192, AES256)
  - ke_state_t enum (IDLE, LOAD, EXPAND, DONE)
  - functions nk_of() and nw_of()
  - function xtime()
  - constant RCON_INIT=8'h01
- Sub-module aes_sbox: combinational 8-bit S-box lookup, instantiated 4 times for SubWord. It is shared with the cipher datapath.

Test Plan:
1. AES-128, FIPS-197 A.1 key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> done 42 edges after start; w[4]=a0fafe17; w[43]=b6630ca6.
2. AES-192, A.2 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> done after 48 edges; w[51]=01002202.
3. AES-256, A.3 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> done after 54 edges; w[59]=706c631e.
4. Start pulsed again at cycle 10 of a run -> ignored; results identical to scenario 1; exactly one done pulse.
5. n_rst=0 at EXPAND cycle 20 -> next cycle busy=0, key_valid=0; new start then completes normally.
6. Run AES-256 then AES-128, and read rd_idx=50 -> with KEY_EXP_ZEROIZE_EN reads 0; without it reads the AES-256 w[50].

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule generator and the cipher datapath.
// Contents:
//   key_len_t   - key length selector (AES128 / AES192 / AES256)
//   ke_state_t  - key-expansion sequencer states
//   RCON_INIT   - first round constant
//   nk_of()     - key length in 32-bit words
//   nw_of()     - total schedule length in 32-bit words
//   xtime()     - multiply by x in GF(2^8)
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'd0,
        AES192 = 2'd1,
        AES256 = 2'd2
    } key_len_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } ke_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [5:0] nk_of(input key_len_t k);
        case (k)
            AES128:  return 6'd4;
            AES192:  return 6'd6;
            default: return 6'd8;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input key_len_t k);
        case (k)
            AES128:  return 6'd44;
            AES192:  return 6'd52;
            default: return 6'd60;
        endcase
    endfunction

    // Reduction by the AES polynomial also gives the 0x80 -> 0x1b rcon step.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Ports:
//   in_byte  - input byte
//   out_byte - substituted byte
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte: its MSB index is 2047 - 8*in_byte.
    logic [10:0] msb_idx;

    assign msb_idx  = {~in_byte, 3'b111};
    assign out_byte = SBOX_TABLE[msb_idx -: 8];

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key-schedule generator. One 32-bit schedule word
// is produced per clock into an internal word store, read back through a
// registered read port (1-cycle latency, old value on same-cycle write).
// Optional feature macro: KEY_EXP_ZEROIZE_EN - the store is cleared on reset
// and LOAD clears every word beyond the new key, so no stale key material
// survives a switch to a shorter key.
// Ports:
//   clk       - clock, rising edge
//   n_rst     - synchronous active-low reset
//   start     - expansion request, sampled only in IDLE
//   key_len   - 0=AES-128, 1=AES-192, 2=AES-256, 3=reserved (ignored)
//   key_in    - key, left-justified (word 0 in the top 32 bits)
//   busy      - high in LOAD and EXPAND
//   done      - one-cycle pulse when the schedule is complete
//   key_valid - store holds a complete schedule
//   rd_idx    - word index to read
//   rd_word   - registered store[rd_idx]; 0 for indices beyond the store
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int MAX_NW = 60,
    parameter int IDX_W  = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [32*MAX_NK-1:0] key_in,
    output logic                 busy,
    output logic                 done,
    output logic                 key_valid,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [31:0]          rd_word
);

    localparam logic [IDX_W:0] NW_LIM = (IDX_W+1)'(MAX_NW);

    ke_state_t              state_q, state_d;
    key_len_t               klen_q, klen_d;
    logic [32*MAX_NK-1:0]   key_q, key_d;
    logic [IDX_W-1:0]       i_q, i_d;
    logic [IDX_W-1:0]       wrap_q, wrap_d;
    logic [7:0]             rcon_q, rcon_d;
    logic                   key_valid_q, key_valid_d;
    logic [31:0]            rd_word_q, rd_word_d;
    logic [31:0]            store_q [MAX_NW];

    logic [IDX_W-1:0]       nk, nw, prev_idx, back_idx;
    logic [31:0]            prev_word, back_word, sub_in, sub_out, t_word, new_word;
    logic                   load_en, exp_en;

    assign nk = IDX_W'(nk_of(klen_q));
    assign nw = IDX_W'(nw_of(klen_q));

    // w[i-1] and w[i-Nk]; guarded so indices outside the store read as 0.
    assign prev_idx  = i_q - IDX_W'(1);
    assign back_idx  = i_q - nk;
    assign prev_word = ({1'b0, prev_idx} < NW_LIM) ? store_q[prev_idx] : '0;
    assign back_word = ({1'b0, back_idx} < NW_LIM) ? store_q[back_idx] : '0;

    // RotWord only applies on the first word of each Nk group.
    assign sub_in = (wrap_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sbox u_sbox0 (.in_byte(sub_in[31:24]), .out_byte(sub_out[31:24]));
    aes_sbox u_sbox1 (.in_byte(sub_in[23:16]), .out_byte(sub_out[23:16]));
    aes_sbox u_sbox2 (.in_byte(sub_in[15:8]),  .out_byte(sub_out[15:8]));
    aes_sbox u_sbox3 (.in_byte(sub_in[7:0]),   .out_byte(sub_out[7:0]));

    always_comb begin
        t_word = prev_word;
        if (wrap_q == '0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (klen_q == AES256 && wrap_q == IDX_W'(4)) begin
            t_word = sub_out;
        end
    end

    assign new_word = back_word ^ t_word;

    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        key_d       = key_q;
        i_d         = i_q;
        wrap_d      = wrap_q;
        rcon_d      = rcon_q;
        key_valid_d = key_valid_q;
        case (state_q)
            IDLE: begin
                if (start && key_len != 2'd3) begin
                    klen_d      = key_len_t'(key_len);
                    key_d       = key_in;
                    key_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                i_d     = nk;
                wrap_d  = '0;
                rcon_d  = RCON_INIT;
                state_d = EXPAND;
            end
            EXPAND: begin
                i_d    = i_q + IDX_W'(1);
                wrap_d = (wrap_q == nk - IDX_W'(1)) ? '0 : wrap_q + IDX_W'(1);
                if (wrap_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == nw - IDX_W'(1)) begin
                    state_d     = DONE;
                    key_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_word_d = ({1'b0, rd_idx} < NW_LIM) ? store_q[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            klen_q      <= AES128;
            i_q         <= '0;
            wrap_q      <= '0;
            rcon_q      <= '0;
            key_valid_q <= 1'b0;
            rd_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            i_q         <= i_d;
            wrap_q      <= wrap_d;
            rcon_q      <= rcon_d;
            key_valid_q <= key_valid_d;
            rd_word_q   <= rd_word_d;
        end
    end

    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    // Store writes are suppressed while reset is asserted.
    assign load_en = n_rst && (state_q == LOAD);
    assign exp_en  = n_rst && (state_q == EXPAND);

    always_ff @(posedge clk) begin
`ifdef KEY_EXP_ZEROIZE_EN
        if (!n_rst) begin
            for (int j = 0; j < MAX_NW; j++) begin
                store_q[j] <= '0;
            end
        end
`endif
        if (load_en) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(nk)) begin
                    store_q[j] <= key_q[32*(MAX_NK-j)-1 -: 32];
                end
            end
`ifdef KEY_EXP_ZEROIZE_EN
            for (int j = 0; j < MAX_NW; j++) begin
                if (j >= int'(nk)) begin
                    store_q[j] <= '0;
                end
            end
`endif
        end
        if (exp_en) begin
            store_q[i_q] <= new_word;
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == EXPAND);
    assign done      = (state_q == DONE);
    assign key_valid = key_valid_q;
    assign rd_word   = rd_word_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: stimulus pushes expected done edges
// and expected read words into queues; independent monitors pop and compare.
module tb_key_expansion_seq;

    localparam int MAX_NK = 8;
    localparam int MAX_NW = 60;
    localparam int IDX_W  = 6;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         key_len = 2'd0;
    logic [255:0]       key_in = '0;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic               busy, done, key_valid;
    logic [31:0]        rd_word;

    int                 errors = 0;
    int                 checks = 0;
    int                 edge_cnt = 0;
    int                 exp_edge;
    int                 done_q[$];
    logic [31:0]        rd_exp_q[$];
    string              rd_name_q[$];
    logic [31:0]        rd_e;
    string              rd_n;
    logic               rd_issue = 1'b0;
    logic               rd_vld_p = 1'b0;

    key_expansion_seq #(.MAX_NK(MAX_NK), .MAX_NW(MAX_NW), .IDX_W(IDX_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .key_valid(key_valid), .rd_idx(rd_idx), .rd_word(rd_word)
    );

    always #5 clk = ~clk;

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Done monitor: each done pulse must match the next expected edge number.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: pulse at edge %0d, none expected", edge_cnt);
            end else begin
                exp_edge = done_q.pop_front();
                check_int("done_edge", edge_cnt, exp_edge);
            end
        end
    end

    // Read monitor: a read issued before an edge is checked at the next falling edge.
    always @(posedge clk) rd_vld_p <= rd_issue;

    always @(negedge clk) begin
        if (rd_vld_p) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: rd_word %h with nothing expected", rd_word);
            end else begin
                rd_e = rd_exp_q.pop_front();
                rd_n = rd_name_q.pop_front();
                check_word(rd_n, rd_word, rd_e);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] len, input logic [255:0] key, input int lat);
        start   = 1'b1;
        key_len = len;
        key_in  = key;
        if (lat > 0) done_q.push_back(edge_cnt + lat);
        tick();
        start = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string name);
        rd_idx   = IDX_W'(idx);
        rd_issue = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done not seen within 100 cycles", name);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_key_valid", key_valid, 1'b0);
        check_word("rst_rd_word", rd_word, 32'h0);
        n_rst = 1'b1;
        tick();

        // AES-128
        do_start(2'd0, K128, 42);
        check_bit("s1_busy", busy, 1'b1);
        wait_done("s1");
        check_bit("s1_key_valid", key_valid, 1'b1);
        check_bit("s1_busy_after", busy, 1'b0);
        rd(4,  32'ha0fafe17, "s1_w4");
        rd(5,  32'h88542cb1, "s1_w5");
        rd(40, 32'hd014f9a8, "s1_w40");
        rd(43, 32'hb6630ca6, "s1_w43");

        // Restart attempt while busy is ignored
        do_start(2'd0, K128, 42);
        repeat (8) tick();
        do_start(2'd2, K256, 0);
        wait_done("s4");
        rd(4,  32'ha0fafe17, "s4_w4");
        rd(43, 32'hb6630ca6, "s4_w43");

        // AES-192
        do_start(2'd1, K192, 48);
        check_bit("s2_key_valid_clr", key_valid, 1'b0);
        wait_done("s2");
        rd(6,  32'hfe0c91f7, "s2_w6");
        rd(7,  32'h2402f5a5, "s2_w7");
        rd(48, 32'he98ba06f, "s2_w48");
        rd(51, 32'h01002202, "s2_w51");

        // AES-256
        do_start(2'd2, K256, 54);
        wait_done("s3");
        rd(8,  32'h9ba35411, "s3_w8");
        rd(12, 32'ha8b09c1a, "s3_w12");
        rd(50, 32'he2757e4f, "s3_w50");
        rd(59, 32'h706c631e, "s3_w59");

        // AES-128 after AES-256: word 50 is outside the new schedule
        do_start(2'd0, K128, 42);
        wait_done("s6");
        rd(43, 32'hb6630ca6, "s6_w43");
`ifdef KEY_EXP_ZEROIZE_EN
        rd(50, 32'h00000000, "s6_w50");
`else
        rd(50, 32'he2757e4f, "s6_w50");
`endif

        // Reserved key length: stays idle, schedule still valid
        do_start(2'd3, K256, 0);
        check_bit("kl3_busy", busy, 1'b0);
        check_bit("kl3_key_valid", key_valid, 1'b1);
        rd(4, 32'ha0fafe17, "kl3_w4");

        // Reset in the middle of EXPAND
        do_start(2'd2, K256, 54);
        repeat (20) tick();
        n_rst = 1'b0;
        done_q.delete();
        tick();
        check_bit("s5_busy", busy, 1'b0);
        check_bit("s5_key_valid", key_valid, 1'b0);
        check_bit("s5_done", done, 1'b0);
        check_word("s5_rd_word", rd_word, 32'h0);
        n_rst = 1'b1;
        tick();
        do_start(2'd1, K192, 48);
        wait_done("s5");
        check_bit("s5_key_valid_after", key_valid, 1'b1);
        rd(8,  32'hec12068e, "s5_w8");
        rd(51, 32'h01002202, "s5_w51");

        // Indices beyond the store read as zero
        rd(60, 32'h00000000, "oob_w60");
        rd(63, 32'h00000000, "oob_w63");

        repeat (3) tick();
        check_int("done_queue_empty", done_q.size(), 0);
        check_int("read_queue_empty", rd_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
